// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared opcodes and FSM state type for the ALU operand sequencer
package alu_op_sequencer_pkg;

    // ALU selector codes; OP_ILLEGAL is the only code the sequencer refuses
    localparam logic [3:0] OP_PASS_A  = 4'd0;
    localparam logic [3:0] OP_PASS_B  = 4'd1;
    localparam logic [3:0] OP_INC_A   = 4'd2;
    localparam logic [3:0] OP_INC_B   = 4'd3;
    localparam logic [3:0] OP_ADD     = 4'd4;
    localparam logic [3:0] OP_ADD_NB  = 4'd5;
    localparam logic [3:0] OP_SUB     = 4'd6;
    localparam logic [3:0] OP_AND     = 4'd7;
    localparam logic [3:0] OP_ILLEGAL = 4'd8;
    localparam logic [3:0] OP_OR      = 4'd9;
    localparam logic [3:0] OP_XOR     = 4'd10;
    localparam logic [3:0] OP_NOT_A   = 4'd11;
    localparam logic [3:0] OP_NOT_B   = 4'd12;
    localparam logic [3:0] OP_SHL     = 4'd13;
    localparam logic [3:0] OP_SHR     = 4'd14;
    localparam logic [3:0] OP_ZERO    = 4'd15;

    // One instruction walks IDLE -> READ -> EXEC -> WB -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_seq_regfile.sv
// rtl/alu_op_sequencer_seq_regfile.sv - operand register bank, two async reads, writeback beats load
module seq_regfile #(
    parameter int DW    = 32,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data
);

    logic [DW-1:0] mem_q [NREGS];
    logic          ld_win;

    // A load colliding with the writeback target is dropped so the ALU result lands
    assign ld_win = ld_en && !(wb_en && (wb_addr == ld_addr));

    // Bank storage: cleared by reset, then written by writeback and/or the load port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (ld_win) begin
                mem_q[ld_addr] <= ld_data;
            end
            if (wb_en) begin
                mem_q[wb_addr] <= wb_data;
            end
        end
    end

    // Read ports are combinational: a same-cycle write is not visible until the next cycle
    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - fetches operands, drives the external ALU and writes its result back
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DW    = 32,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_ra,
    input  logic [AW-1:0] instr_rb,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [3:0]    alu_sel,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_y,
    output logic          res_valid,
    output logic [AW-1:0] res_rd,
    output logic [DW-1:0] res_data,
    output logic          res_zero,
    output logic          illegal_op
);

    seq_state_e    state_q, state_d;
    logic          alive_q;
    logic [3:0]    op_q;
    logic [AW-1:0] rd_q, ra_q, rb_q;
    logic [3:0]    alu_sel_q;
    logic [DW-1:0] alu_a_q, alu_b_q;
    logic [DW-1:0] result_q;
    logic          illegal_q;
    logic          accept;
    logic          wb_en;
    logic [DW-1:0] ra_data, rb_data;

    // alive_q keeps ready low while in reset and for the edge that releases it
    assign instr_ready = (state_q == ST_IDLE) && alive_q;
    assign accept      = instr_valid && instr_ready;
    assign wb_en       = (state_q == ST_WB);

    // Next-state logic; an illegal opcode is consumed but never leaves IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && (instr_op != OP_ILLEGAL)) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    // Instruction fields captured at the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            rd_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
        end else if (accept) begin
            op_q <= instr_op;
            rd_q <= instr_rd;
            ra_q <= instr_ra;
            rb_q <= instr_rb;
        end
    end

    // Registered ALU inputs, loaded in READ and held afterwards so EXEC sees stable operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_sel_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
        end else if (state_q == ST_READ) begin
            alu_sel_q <= op_q;
            alu_a_q   <= ra_data;
            alu_b_q   <= rb_data;
        end
    end

    // ALU result sampled at the end of EXEC, consumed in WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else if (state_q == ST_EXEC) begin
            result_q <= alu_y;
        end
    end

    // One-cycle pulse in the cycle after an illegal opcode is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && (instr_op == OP_ILLEGAL);
        end
    end

    seq_regfile #(
        .DW    (DW),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_en   (wb_en),
        .wb_addr (rd_q),
        .wb_data (result_q),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .ra_addr (ra_q),
        .ra_data (ra_data),
        .rb_addr (rb_q),
        .rb_data (rb_data)
    );

    assign alu_sel    = alu_sel_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign illegal_op = illegal_q;

    // Result report is only meaningful during WB and reads zero otherwise
    assign res_valid = wb_en;
    assign res_rd    = wb_en ? rd_q : '0;
    assign res_data  = wb_en ? result_q : '0;
    assign res_zero  = wb_en && (result_q == '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [2:0]  instr_rd, instr_ra, instr_rb;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  alu_sel;
    logic [31:0] alu_a, alu_b, alu_y;
    logic        res_valid;
    logic [2:0]  res_rd;
    logic [31:0] res_data;
    logic        res_zero;
    logic        illegal_op;

    int checks   = 0;
    int failures = 0;

    alu_op_sequencer #(.DW(32), .NREGS(8), .AW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_ra    (instr_ra),
        .instr_rb    (instr_rb),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_sel     (alu_sel),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_y       (alu_y),
        .res_valid   (res_valid),
        .res_rd      (res_rd),
        .res_data    (res_data),
        .res_zero    (res_zero),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            4'd0:  return a;
            4'd1:  return b;
            4'd2:  return a + 32'd1;
            4'd3:  return b + 32'd1;
            4'd4:  return a + b;
            4'd5:  return a + ~b;
            4'd6:  return a - b;
            4'd7:  return a & b;
            4'd9:  return a | b;
            4'd10: return a ^ b;
            4'd11: return ~a;
            4'd12: return ~b;
            4'd13: return a << b[4:0];
            4'd14: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_y = alu_model(alu_sel, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Issue one instruction from IDLE and follow it to WB; optionally fire ld_en in the WB cycle
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                         input logic wb_ld, input logic [2:0] wb_ld_addr, input logic [31:0] wb_ld_data,
                         output logic [31:0] data, output logic [2:0] rdo, output logic zero,
                         output int lat, output int low);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
        tick();
        instr_valid = 1'b0;
        lat = 1;
        low = 0;
        while (!res_valid && lat < 10) begin
            if (!instr_ready) low++;
            tick();
            lat++;
        end
        if (!instr_ready) low++;
        data = res_data;
        rdo  = res_rd;
        zero = res_zero;
        if (wb_ld) begin
            ld_en = 1'b1; ld_addr = wb_ld_addr; ld_data = wb_ld_data;
        end
        tick();
        ld_en = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic wb_ld, input logic [31:0] wb_ld_data,
                       input logic [31:0] exp);
        logic [31:0] d;
        logic [2:0]  r;
        logic        z;
        int          lat, low;
        issue(op, rd, ra, rb, wb_ld, rd, wb_ld_data, d, r, z, lat, low);
        chk({tag, ".latency"}, lat, 3);
        chk({tag, ".res_data"}, d, exp);
        chk({tag, ".res_rd"}, {29'd0, r}, {29'd0, rd});
        chk({tag, ".res_zero"}, {31'd0, z}, {31'd0, (exp == 32'd0)});
        chk({tag, ".ready_low"}, low, 3);
    endtask

    task automatic read_reg(input string tag, input logic [2:0] r, input logic [31:0] exp);
        run(tag, 4'd0, r, r, 3'd0, 1'b0, 32'd0, exp);
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_ra = '0; instr_rb = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        tick();
        tick();
        chk("rst.ready", {31'd0, instr_ready}, 32'd0);
        chk("rst.res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst.alu_sel", {28'd0, alu_sel}, 32'd0);
        chk("rst.alu_a", alu_a, 32'd0);
        chk("rst.alu_b", alu_b, 32'd0);
        chk("rst.res_data", res_data, 32'd0);
        chk("rst.illegal", {31'd0, illegal_op}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release.ready_before_edge", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("release.ready", {31'd0, instr_ready}, 32'd1);

        // ADD r3 = r1 + r2
        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        run("add", 4'd4, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, 32'd8);
        chk("add.alu_sel_hold", {28'd0, alu_sel}, 32'd4);
        read_reg("add.bank3", 3'd3, 32'd8);

        // SUB to zero, INC wrap
        load(3'd1, 32'd3);
        run("sub_zero", 4'd6, 3'd4, 3'd1, 3'd2, 1'b0, 32'd0, 32'd0);
        load(3'd6, 32'hFFFF_FFFF);
        run("inc_wrap", 4'd2, 3'd7, 3'd6, 3'd0, 1'b0, 32'd0, 32'd0);

        // Illegal opcode: one-cycle pulse, no result, no write
        instr_valid = 1'b1; instr_op = 4'd8; instr_rd = 3'd1; instr_ra = 3'd2; instr_rb = 3'd2;
        tick();
        instr_valid = 1'b0;
        chk("illegal.pulse", {31'd0, illegal_op}, 32'd1);
        chk("illegal.ready", {31'd0, instr_ready}, 32'd1);
        chk("illegal.no_res", {31'd0, res_valid}, 32'd0);
        tick();
        chk("illegal.pulse_end", {31'd0, illegal_op}, 32'd0);
        chk("illegal.no_res2", {31'd0, res_valid}, 32'd0);
        tick();
        chk("illegal.no_res3", {31'd0, res_valid}, 32'd0);
        read_reg("illegal.bank1", 3'd1, 32'd3);

        // Back-to-back: second instruction must see the freshly written r3
        load(3'd1, 32'd5);
        load(3'd3, 32'h100);
        run("b2b.first", 4'd4, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, 32'd8);
        run("b2b.second", 4'd4, 3'd4, 3'd3, 3'd2, 1'b0, 32'd0, 32'd11);

        // Load colliding with writeback loses
        load(3'd3, 32'd0);
        run("collide", 4'd4, 3'd3, 3'd1, 3'd2, 1'b1, 32'h0000_DEAD, 32'd8);
        read_reg("collide.bank3", 3'd3, 32'd8);

        // Shift and forced-zero selectors
        run("shl", 4'd13, 3'd5, 3'd1, 3'd2, 1'b0, 32'd0, 32'd40);
        run("zero_op", 4'd15, 3'd6, 3'd1, 3'd2, 1'b0, 32'd0, 32'd0);

        // Reset during EXEC aborts the instruction and clears the bank
        for (int i = 0; i < 8; i++) load(i[2:0], 32'h10 + i);
        instr_valid = 1'b1; instr_op = 4'd4; instr_rd = 3'd0; instr_ra = 3'd1; instr_rb = 3'd2;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("abort.alu_a_exec", alu_a, 32'h11);
        rst_n = 1'b0;
        #1;
        chk("abort.res_valid", {31'd0, res_valid}, 32'd0);
        chk("abort.ready", {31'd0, instr_ready}, 32'd0);
        chk("abort.alu_a", alu_a, 32'd0);
        tick();
        chk("abort.res_valid2", {31'd0, res_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort.ready_before_edge", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("abort.ready_after", {31'd0, instr_ready}, 32'd1);
        chk("abort.res_valid3", {31'd0, res_valid}, 32'd0);
        for (int i = 0; i < 8; i++) read_reg($sformatf("abort.bank%0d", i), i[2:0], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
